// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Fetch stage ahead of decode/execute. Owns the fetch PC, issues
//               in-order imem reads under a credit limit, buffers responses in
//               a first-word-fall-through prefetch queue and presents one
//               instruction per cycle over valid/ready. Redirects flush the
//               queue and discard responses still in flight.
//               Optional macro FETCH_PERF_EN adds saturating perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter int              PC_W     = 19,
  parameter int              INSTR_W  = 19,
  parameter int              QDEPTH   = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall,
  output logic [15:0]        perf_flush
`endif
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = $clog2(QDEPTH) + 1;
  localparam logic [CNT_W:0] C_DEPTH = (CNT_W + 1)'(QDEPTH);

  logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]   out_q, out_d;
  logic [CNT_W-1:0]   drop_q, drop_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   rd_q, rd_d;
  logic [PTR_W-1:0]   wr_q, wr_d;
  logic [INSTR_W-1:0] data_q [QDEPTH];
  logic [PC_W-1:0]    tag_q  [QDEPTH];

  logic               rsp;
  logic               push;
  logic               pop;
  logic [PC_W-1:0]    rsp_tag;

  // Handshake outputs, credit check and response classification
  always_comb begin
    instr_valid = !reset && (cnt_q != '0);
    imem_req    = !reset && !redirect_valid &&
                  (({1'b0, cnt_q} + {1'b0, out_q}) < C_DEPTH);
    imem_addr   = reset ? RESET_PC : fetch_pc_q;
    instr       = instr_valid ? data_q[rd_q] : '0;
    instr_pc    = instr_valid ? tag_q[rd_q]  : '0;
    // Guard on out_q keeps the counter from underflowing on a stray rvalid
    rsp         = imem_rvalid && !reset && (out_q != '0);
    push        = rsp && !redirect_valid && (drop_q == '0);
    pop         = instr_valid && instr_ready;
    // Surviving in-flight requests are contiguous and end at fetch_pc-1,
    // so the oldest one's address is fetch_pc minus their count
    rsp_tag     = fetch_pc_q - PC_W'(out_q - drop_q);
  end

  // Next-state for PC, credit counters and queue pointers
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    out_d      = out_q + CNT_W'(imem_req) - CNT_W'(rsp);
    drop_d     = drop_q;
    cnt_d      = cnt_q + CNT_W'(push) - CNT_W'(pop);
    rd_d       = rd_q + PTR_W'(pop);
    wr_d       = wr_q + PTR_W'(push);
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      drop_d     = out_q - CNT_W'(rsp);
      cnt_d      = '0;
      rd_d       = '0;
      wr_d       = '0;
    end else begin
      if (imem_req) begin
        fetch_pc_d = fetch_pc_q + PC_W'(1);
      end
      if (rsp && (drop_q != '0)) begin
        drop_d = drop_q - CNT_W'(1);
      end
    end
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
      cnt_q      <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
    end
  end

  // Queue storage; contents are only visible through a valid head entry
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_q] <= imem_rdata;
      tag_q[wr_q]  <= rsp_tag;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_stall_q;
  logic [15:0] perf_flush_q;

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
      perf_flush_q   <= '0;
    end else begin
      if (pop && (perf_fetched_q != '1)) perf_fetched_q <= perf_fetched_q + 32'd1;
      if (!instr_valid && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 32'd1;
      if (redirect_valid && (perf_flush_q != '1)) perf_flush_q <= perf_flush_q + 16'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
  assign perf_flush   = perf_flush_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Randomized bench for instr_fetch_unit. An in-order imem model
//               with random latency answers requests; a transaction-level
//               scoreboard (epoch-tagged requests, queue of expected words)
//               predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  localparam int          PC_W   = 19;
  localparam int          INSTR_W = 19;
  localparam int          QDEPTH = 4;
  localparam logic [18:0] RST_PC = 19'h7FFFE;

  logic               clk = 1'b0;
  logic               reset;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    instr_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
  logic [15:0] perf_flush;
`endif

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .QDEPTH(QDEPTH), .RESET_PC(RST_PC)
  ) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall), .perf_flush(perf_flush)
`endif
  );

  typedef struct { logic [18:0] pc; logic [18:0] data; } ent_t;
  typedef struct { logic [18:0] addr; int epoch; int due; } req_t;

  ent_t        mq[$];    // words the CPU should see, oldest first
  req_t        pend[$];  // requests issued, response not yet returned
  logic [18:0] mpc;      // next address the fetch unit should request
  int          epoch = 0;
  int          cyc = 0;
  int          last_due = 0;
  int          n_acc = 0;
  int          m_fetched = 0, m_stall = 0, m_flush = 0;
  int          total = 0, bad = 0;

  int          p_ready = 100, p_redir = 0, lat_min = 1, lat_max = 1;
  bit          force_redir = 1'b0;
  logic [18:0] force_pc = '0;

  function automatic logic [18:0] memw(input logic [18:0] a);
    return (a * 19'd677) ^ 19'h2A5A5 ^ {a[3:0], a[18:4]};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: drive at negedge, check outputs, advance the model
  task automatic step(input bit rst);
    bit          rsp;
    bit          exp_req;
    req_t        r;
    int          due;
    int          sel;
    @(negedge clk);
    reset          = rst;
    redirect_valid = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    instr_ready    = ($urandom_range(99) < p_ready);
    rsp            = 1'b0;
    if (!rst) begin
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        rsp         = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = memw(pend[0].addr);
      end
      if (force_redir) begin
        redirect_valid = 1'b1;
        redirect_pc    = force_pc;
        force_redir    = 1'b0;
      end else if ($urandom_range(99) < p_redir) begin
        redirect_valid = 1'b1;
        sel = $urandom_range(3);
        case (sel)
          0:       redirect_pc = 19'h00100;
          1:       redirect_pc = 19'h7FFFF;
          2:       redirect_pc = 19'h7FFFD;
          default: redirect_pc = PC_W'($urandom);
        endcase
      end
    end
    #1;
    if (rst) begin
      check_val("rst_req",   {31'd0, imem_req},    32'd0);
      check_val("rst_addr",  {13'd0, imem_addr},   {13'd0, RST_PC});
      check_val("rst_valid", {31'd0, instr_valid}, 32'd0);
      check_val("rst_instr", {13'd0, instr},       32'd0);
      check_val("rst_pc",    {13'd0, instr_pc},    32'd0);
    end else begin
      exp_req = !redirect_valid && ((mq.size() + pend.size()) < QDEPTH);
      check_val("valid", {31'd0, instr_valid}, {31'd0, mq.size() != 0});
      if (mq.size() != 0) begin
        check_val("instr_pc", {13'd0, instr_pc}, {13'd0, mq[0].pc});
        check_val("instr",    {13'd0, instr},    {13'd0, mq[0].data});
      end
      check_val("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
      if (exp_req) check_val("imem_addr", {13'd0, imem_addr}, {13'd0, mpc});
    end
    // model update for the upcoming rising edge
    if (rst) begin
      mq.delete();
      pend.delete();
      mpc       = RST_PC;
      epoch++;
      last_due  = cyc;
      m_fetched = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (mq.size() == 0) m_stall++;
      if (mq.size() != 0 && instr_ready) begin
        void'(mq.pop_front());
        n_acc++;
        m_fetched++;
      end
      if (rsp) begin
        r = pend.pop_front();
        if (!redirect_valid && r.epoch == epoch)
          mq.push_back('{pc: r.addr, data: memw(r.addr)});
      end
      if (redirect_valid) begin
        mq.delete();
        epoch++;
        m_flush++;
        mpc = redirect_pc;
      end else if (exp_req) begin
        due = cyc + $urandom_range(lat_max, lat_min);
        if (due <= last_due) due = last_due + 1;
        pend.push_back('{addr: mpc, epoch: epoch, due: due});
        last_due = due;
        mpc      = mpc + 19'd1;
      end
    end
    cyc++;
  endtask

  initial begin
    reset          = 1'b1;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;

    repeat (3) step(1'b1);

    // streaming with 1-cycle memory and wrap from 0x7FFFE through 0
    p_ready = 100; p_redir = 0; lat_min = 1; lat_max = 1;
    repeat (20) step(1'b0);

    // CPU stalled: credit limit must stop requests at queue depth
    p_ready = 0;
    repeat (10) step(1'b0);
    p_ready = 100;
    repeat (10) step(1'b0);

    // redirect while responses are in flight with latency 3
    lat_min = 3; lat_max = 3;
    repeat (10) step(1'b0);
    force_redir = 1'b1; force_pc = 19'h00100;
    repeat (15) step(1'b0);

    // mixed random traffic
    p_ready = 70; p_redir = 5; lat_min = 1; lat_max = 4;
    repeat (3000) step(1'b0);

    // reset mid-stream with a full queue
    p_ready = 0; p_redir = 0;
    repeat (10) step(1'b0);
    repeat (2) step(1'b1);
    p_ready = 100;
    repeat (20) step(1'b0);

    // frequent, often back-to-back redirects
    p_ready = 60; p_redir = 20; lat_min = 1; lat_max = 3;
    repeat (2000) step(1'b0);

`ifdef FETCH_PERF_EN
    @(negedge clk);
    check_val("perf_fetched", perf_fetched, m_fetched);
    check_val("perf_stall",   perf_stall,   m_stall);
    check_val("perf_flush",   {16'd0, perf_flush}, m_flush);
`endif

    check_val("accepts_seen", {31'd0, n_acc > 500}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
